abc_stimulus_sequencer: RTL and testbench
=========================================

// Module: abc_stimulus_sequencer
// PURPOSE
//  Upstream stimulus stage for the 3-input combinational gate blocks (A,B,C -> X).
//  Walks the input pattern bus through every binary code 0..2^WIDTH-1, holding each
//  for HOLD_CYCLES clocks, with a start/abort/done handshake. It replaces hand-written
//  #delay stimulus. Optionally samples the DUT's X output per pattern into a truth table.
// PARAMETERS
//  WIDTH        3   pattern width, legal 1..8; pattern[WIDTH-1] drives A, pattern[0] drives C
//  HOLD_CYCLES  10  clocks each pattern is held, legal >= 1; counter width $clog2(HOLD_CYCLES+1)
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  start      in   1              begin a sweep; sampled only in IDLE
//  abort      in   1              synchronous cancel; sampled in every state
//  x_in       in   1              DUT output X, captured only with SEQ_CAPTURE_EN
//  pattern    out  WIDTH          current input code to DUT (A = MSB)
//  valid      out  1              pattern is driven by an active sweep
//  sample     out  1              last cycle of the current hold window
//  busy       out  1              state == RUN
//  done       out  1              one-cycle pulse after the final window completes
//  x_table    out  2**WIDTH       captured X per pattern; bit i holds X for pattern i
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pattern=0, hold_cnt=0, valid=0, sample=0, busy=0,
//   done=0, x_table=0. Deassertion of reset is taken synchronously; first active edge after.
//  States: IDLE, RUN, DONE (2-bit encoding, registered outputs).
//  IDLE: start=1 & abort=0 -> RUN, pattern=0, hold_cnt=0, x_table=0. Else stay, pattern=0.
//  RUN: hold_cnt increments each clock. sample=1 combinationally while hold_cnt==HOLD_CYCLES-1.
//   On that edge: if pattern==2^WIDTH-1 -> DONE; else pattern+1, hold_cnt=0.
//   start is ignored in RUN. Total sweep = 2^WIDTH*HOLD_CYCLES clocks with valid=1.
//  DONE: done=1, valid=0, pattern holds the last code, one cycle, then -> IDLE unconditionally.
//  abort=1: any state -> IDLE next edge, pattern=0, hold_cnt=0, no done pulse, x_table kept.
//   abort and start together in IDLE: abort wins, stay IDLE.
//  Latency: start sampled at edge k -> pattern=0, valid=1 from edge k; done at edge
//   k + 2^WIDTH*HOLD_CYCLES.
//  HOLD_CYCLES=1: sample is high every RUN cycle; a new pattern every clock.
//  Pattern never wraps: the increment is suppressed on the final code.
//  Reset mid-sweep: all registers return to reset values immediately, no done pulse.
// CONFIGURATION
//  SEQ_CAPTURE_EN defined: on each RUN edge with sample=1, x_table[pattern] <= x_in;
//   cleared on the IDLE->RUN transition and on reset. The table is stable from the done pulse.
//  SEQ_CAPTURE_EN undefined: no capture flops; x_table tied to 0, x_in unused.
//   All other behaviour is identical.
// TESTING
//  1 reset: rst_n=0 mid-RUN at pattern=5 -> all outputs 0 that cycle, state IDLE.
//  2 full sweep, WIDTH=3, HOLD=10: start pulse -> pattern 0..7, each held exactly 10 clks,
//    sample high on clk 9 of each window; done pulse 80 clks after start.
//  3 abort at pattern=3, hold_cnt=4 -> next edge IDLE, pattern=0, valid=0, no done;
//    a new start restarts at 0.
//  4 start during RUN and start+abort in IDLE -> ignored / stays IDLE.
//  5 HOLD_CYCLES=1: pattern increments every clk 0..7; done at clk 8; sample constant 1.
//  6 SEQ_CAPTURE_EN, x_in = A&B|C model -> x_table=8'b1110_1010 at done; undefined -> 8'h00.

Source files
------------

// File: rtl/abc_stimulus_sequencer.sv
// Stimulus sequencer for 3-input gate blocks: sweeps every code 0..2^WIDTH-1, holding each for HOLD_CYCLES clocks.
// Optional per-pattern truth-table capture of x_in is enabled by defining SEQ_CAPTURE_EN.
module abc_stimulus_sequencer #(
    parameter int WIDTH       = 3,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  x_in,
    output logic [WIDTH-1:0]      pattern,
    output logic                  valid,
    output logic                  sample,
    output logic                  busy,
    output logic                  done,
    output logic [2**WIDTH-1:0]   x_table
);

    localparam int                CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [WIDTH-1:0]  LAST_CODE = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             window_end;
    logic             launch;

    assign window_end = (state_q == ST_RUN) && (hold_cnt_q == HOLD_LAST);
    assign launch     = (state_q == ST_IDLE) && start && !abort;

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                pattern_d  = '0;
                hold_cnt_d = '0;
                if (launch) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (window_end) begin
                    hold_cnt_d = '0;
                    // The final code is held through DONE instead of wrapping to 0.
                    if (pattern_q == LAST_CODE) begin
                        state_d = ST_DONE;
                    end else begin
                        pattern_d = pattern_q + 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                pattern_d  = '0;
                hold_cnt_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                pattern_d  = '0;
                hold_cnt_d = '0;
            end
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            pattern_d  = '0;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pattern_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign pattern = pattern_q;
    assign valid   = (state_q == ST_RUN);
    assign busy    = (state_q == ST_RUN);
    assign sample  = window_end;
    assign done    = (state_q == ST_DONE);

`ifdef SEQ_CAPTURE_EN
    logic [2**WIDTH-1:0] x_table_q, x_table_d;

    // An abort on the sampling edge leaves the table untouched.
    always_comb begin
        x_table_d = x_table_q;
        if (launch) begin
            x_table_d = '0;
        end else if (window_end && !abort) begin
            x_table_d[pattern_q] = x_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_table_q <= '0;
        end else begin
            x_table_q <= x_table_d;
        end
    end

    assign x_table = x_table_q;
`else
    logic unused_x_in;

    assign unused_x_in = x_in;
    assign x_table     = '0;
`endif

endmodule

// File: tb/tb_abc_stimulus_sequencer.sv
// Randomized self-checking bench for abc_stimulus_sequencer (HOLD_CYCLES=10 and HOLD_CYCLES=1 instances).
// Expected behaviour comes from a cycle-indexed model of the sweep, not from the RTL structure.
module tb_abc_stimulus_sequencer;

    localparam int N  = 8;
    localparam int HA = 10;
    localparam int HB = 1;
`ifdef SEQ_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, abort_a = 1'b0, xin_a;
    logic [2:0] pat_a;
    logic       valid_a, sample_a, busy_a, done_a;
    logic [7:0] xt_a;
    logic       start_b = 1'b0, abort_b = 1'b0, xin_b;
    logic [2:0] pat_b;
    logic       valid_b, sample_b, busy_b, done_b;
    logic [7:0] xt_b;

    // Truth tables standing in for the gate under test.
    logic [7:0] tt_a = 8'h00, tt_b = 8'h00;
    assign xin_a = tt_a[pat_a];
    assign xin_b = tt_b[pat_b];

    int checks = 0;
    int errors = 0;

    abc_stimulus_sequencer #(.WIDTH(3), .HOLD_CYCLES(HA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .x_in(xin_a),
        .pattern(pat_a), .valid(valid_a), .sample(sample_a), .busy(busy_a),
        .done(done_a), .x_table(xt_a)
    );

    abc_stimulus_sequencer #(.WIDTH(3), .HOLD_CYCLES(HB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .x_in(xin_b),
        .pattern(pat_b), .valid(valid_b), .sample(sample_b), .busy(busy_b),
        .done(done_b), .x_table(xt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] obs(input bit b);
        if (b) return {pat_b, valid_b, busy_b, sample_b, done_b};
        return {pat_a, valid_a, busy_a, sample_a, done_a};
    endfunction

    function automatic logic [7:0] tab(input bit b);
        return b ? xt_b : xt_a;
    endfunction

    task automatic drive(input bit b, input logic s, input logic a);
        if (b) begin
            start_b = s;
            abort_b = a;
        end else begin
            start_a = s;
            abort_a = a;
        end
    endtask

    // Full sweep on instance b (0 = HOLD 10, 1 = HOLD 1); optional random start toggling while running.
    task automatic sweep(input bit b, input int h, input bit jitter, input logic [7:0] tt, input string tag);
        logic [6:0] exp;
        logic [7:0] exp_tab;
        exp_tab = CAP ? tt : 8'h00;
        drive(b, 1'b1, 1'b0);
        tick();
        drive(b, 1'b0, 1'b0);
        for (int c = 0; c < N * h; c++) begin
            exp = {3'(c / h), 1'b1, 1'b1, 1'((c % h) == (h - 1)), 1'b0};
            checks++;
            if (obs(b) !== exp) begin
                errors++;
                $display("FAIL %s run cycle %0d: got %b expected %b", tag, c, obs(b), exp);
            end
            if (jitter) drive(b, 1'($urandom % 2), 1'b0);
            tick();
        end
        drive(b, 1'b0, 1'b0);
        exp = {3'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs(b) !== exp) begin
            errors++;
            $display("FAIL %s done cycle: got %b expected %b", tag, obs(b), exp);
        end
        checks++;
        if (tab(b) !== exp_tab) begin
            errors++;
            $display("FAIL %s table at done: got %h expected %h", tag, tab(b), exp_tab);
        end
        tick();
        checks++;
        if (obs(b) !== 7'b0 || tab(b) !== exp_tab) begin
            errors++;
            $display("FAIL %s idle after done: got %b/%h expected %b/%h", tag, obs(b), tab(b), 7'b0, exp_tab);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (obs(0) !== 7'b0 || obs(1) !== 7'b0 || xt_a !== 8'h00 || xt_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_initial: got %b %b %h %h expected all zero", obs(0), obs(1), xt_a, xt_b);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs(0) !== 7'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected %b", obs(0), 7'b0);
        end
        tt_a = 8'($urandom);
        drive(0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0);
        for (int i = 0; i < 5 * HA + 3; i++) tick();
        checks++;
        if (obs(0) !== {3'd5, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_pre_pattern5: got %b expected %b", obs(0), {3'd5, 4'b1100});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs(0) !== 7'b0 || xt_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_midrun: got %b/%h expected %b/%h", obs(0), xt_a, 7'b0, 8'h00);
        end
        tick();
        rst_n = 1'b1;
        begin
            bit bad;
            bad = 1'b0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (obs(0) !== 7'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL reset_stays_idle: got activity expected idle and no done");
            end
        end
    endtask

    task automatic test_full_sweep();
        for (int i = 0; i < N; i++) tt_a[i] = (i[2] & i[1]) | i[0];
        checks++;
        if (tt_a !== 8'b1110_1010) begin
            errors++;
            $display("FAIL abc_model_table: got %b expected %b", tt_a, 8'b1110_1010);
        end
        sweep(0, HA, 1'b0, tt_a, "sweep_abc");
        for (int r = 0; r < 2; r++) begin
            tt_a = 8'($urandom);
            sweep(0, HA, 1'b0, tt_a, "sweep_rand");
        end
    endtask

    task automatic test_abort_one(input int p, input int h);
        logic [7:0] mask;
        logic [7:0] exp_tab;
        bit bad;
        tt_a = 8'($urandom);
        mask = (8'd1 << p) - 8'd1;
        exp_tab = CAP ? (tt_a & mask) : 8'h00;
        drive(0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0);
        for (int i = 0; i < p * HA + h; i++) tick();
        checks++;
        if (obs(0) !== {3'(p), 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_pre p=%0d h=%0d: got %b expected %b", p, h, obs(0), {3'(p), 4'b1100});
        end
        drive(0, 1'b0, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0);
        checks++;
        if (obs(0) !== 7'b0 || xt_a !== exp_tab) begin
            errors++;
            $display("FAIL abort_idle p=%0d h=%0d: got %b/%h expected %b/%h", p, h, obs(0), xt_a, 7'b0, exp_tab);
        end
        bad = 1'b0;
        for (int i = 0; i < N * HA; i++) begin
            tick();
            if (obs(0) !== 7'b0 || xt_a !== exp_tab) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_quiet p=%0d: got activity or table change expected idle", p);
        end
        drive(0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0);
        checks++;
        if (obs(0) !== 7'b0001100) begin
            errors++;
            $display("FAIL abort_restart: got %b expected %b", obs(0), 7'b0001100);
        end
        drive(0, 1'b0, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        test_abort_one(3, 4);
        for (int r = 0; r < 3; r++) test_abort_one(int'($urandom_range(7, 0)), int'($urandom_range(HA - 2, 0)));
    endtask

    task automatic test_start_ignored();
        bit bad;
        tt_a = 8'($urandom);
        sweep(0, HA, 1'b1, tt_a, "start_in_run");
        drive(0, 1'b1, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (obs(0) !== 7'b0) bad = 1'b1;
        end
        drive(0, 1'b0, 1'b0);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL start_abort_idle: got %b expected %b", obs(0), 7'b0);
        end
    endtask

    task automatic test_hold1();
        for (int r = 0; r < 3; r++) begin
            tt_b = 8'($urandom);
            sweep(1, HB, 1'b0, tt_b, "hold1");
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_full_sweep();
        test_abort();
        test_start_ignored();
        test_hold1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
